// File: rtl/ex_issue_controller.sv
// Issue/hazard control between decode and execute: scoreboard, forwarding, stalls and branch flush.
// Optional build macro EX_ISSUE_STATS_EN adds saturating stall/forward/flush counters.
module ex_issue_controller #(
    parameter int REG_BITS     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_wr,
    input  logic                id_load,
    input  logic [1:0]          id_sel1,
    input  logic [1:0]          id_sel2,
    input  logic                ex_branch_taken,
`ifdef EX_ISSUE_STATS_EN
    output logic [15:0]         stat_stalls,
    output logic [15:0]         stat_fwds,
    output logic [15:0]         stat_flushes,
`endif
    output logic                stall,
    output logic                flush,
    output logic                ex_valid,
    output logic [REG_BITS-1:0] ex_rd,
    output logic [1:0]          ex_aluin1,
    output logic [1:0]          ex_aluin2
);

    typedef enum logic {RUN, FLUSH} state_e;

    state_e              state_q;
    logic [2:0]          cnt_q;
    logic                ex_v_q, ex_wr_q, ex_ld_q;
    logic [REG_BITS-1:0] ex_rd_q;
    logic                mem_v_q, mem_wr_q;
    logic [REG_BITS-1:0] mem_rd_q;
    logic [1:0]          a1_q, a2_q;

    logic                run, use1, use2, exm1, exm2, memm1, memm2;
    logic                fwd1, fwd2, haz1, haz2, issue;
    logic [1:0]          sel1_d, sel2_d;

    assign run = (state_q == RUN);

    always_comb begin
        use1  = (id_sel1 == 2'b01) && (id_rs1 != '0);
        use2  = (id_sel2 == 2'b00) && (id_rs2 != '0);
        exm1  = ex_v_q && ex_wr_q && (ex_rd_q == id_rs1);
        exm2  = ex_v_q && ex_wr_q && (ex_rd_q == id_rs2);
        memm1 = mem_v_q && mem_wr_q && (mem_rd_q == id_rs1);
        memm2 = mem_v_q && mem_wr_q && (mem_rd_q == id_rs2);
        // EX match shadows an older MEM match to the same register
        fwd1  = use1 && exm1 && !ex_ld_q;
        fwd2  = use2 && exm2 && !ex_ld_q;
        haz1  = use1 && ((exm1 && ex_ld_q) || (!exm1 && memm1));
        haz2  = use2 && ((exm2 && ex_ld_q) || (!exm2 && memm2));
        sel1_d = fwd1 ? 2'b10 : id_sel1;
        sel2_d = fwd2 ? 2'b11 : id_sel2;
    end

    assign stall = rst && id_valid && run && !ex_branch_taken && (haz1 || haz2);
    assign flush = rst && !run;
    assign issue = run && id_valid && !stall && !ex_branch_taken;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            ex_v_q   <= 1'b0;
            ex_wr_q  <= 1'b0;
            ex_ld_q  <= 1'b0;
            ex_rd_q  <= '0;
            mem_v_q  <= 1'b0;
            mem_wr_q <= 1'b0;
            mem_rd_q <= '0;
            a1_q     <= 2'b00;
            a2_q     <= 2'b00;
        end else begin
            mem_v_q  <= ex_v_q;
            mem_wr_q <= ex_wr_q;
            mem_rd_q <= ex_rd_q;
            ex_v_q   <= issue;
            ex_wr_q  <= issue && id_wr;
            ex_ld_q  <= issue && id_load;
            ex_rd_q  <= issue ? id_rd : '0;
            a1_q     <= issue ? sel1_d : 2'b00;
            a2_q     <= issue ? sel2_d : 2'b00;
            unique case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        state_q <= FLUSH;
                        cnt_q   <= 3'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    if (cnt_q == 3'd0) state_q <= RUN;
                    else               cnt_q   <= cnt_q - 3'd1;
                end
            endcase
        end
    end

    assign ex_valid  = ex_v_q;
    assign ex_rd     = ex_rd_q;
    assign ex_aluin1 = a1_q;
    assign ex_aluin2 = a2_q;

`ifdef EX_ISSUE_STATS_EN
    logic [15:0] st_stalls_q, st_fwds_q, st_flushes_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_stalls_q  <= '0;
            st_fwds_q    <= '0;
            st_flushes_q <= '0;
        end else begin
            if (stall && st_stalls_q != 16'hFFFF)
                st_stalls_q <= st_stalls_q + 16'd1;
            if (issue && (fwd1 || fwd2) && st_fwds_q != 16'hFFFF)
                st_fwds_q <= st_fwds_q + 16'd1;
            if (run && ex_branch_taken && st_flushes_q != 16'hFFFF)
                st_flushes_q <= st_flushes_q + 16'd1;
        end
    end

    assign stat_stalls  = st_stalls_q;
    assign stat_fwds    = st_fwds_q;
    assign stat_flushes = st_flushes_q;
`endif

endmodule

// File: tb/tb_ex_issue_controller.sv
// Bench for ex_issue_controller: directed vector tables plus randomized run
// against a pipeline-history reference model.
module tb_ex_issue_controller;

    localparam int FC = 2;

    logic       clk, rst, id_valid, id_wr, id_load, ex_branch_taken;
    logic [3:0] id_rs1, id_rs2, id_rd;
    logic [1:0] id_sel1, id_sel2;
    logic       stall, flush, ex_valid;
    logic [3:0] ex_rd;
    logic [1:0] ex_aluin1, ex_aluin2;
`ifdef EX_ISSUE_STATS_EN
    logic [15:0] stat_stalls, stat_fwds, stat_flushes;
`endif

    ex_issue_controller #(.REG_BITS(4), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_wr(id_wr), .id_load(id_load),
        .id_sel1(id_sel1), .id_sel2(id_sel2),
        .ex_branch_taken(ex_branch_taken),
`ifdef EX_ISSUE_STATS_EN
        .stat_stalls(stat_stalls), .stat_fwds(stat_fwds),
        .stat_flushes(stat_flushes),
`endif
        .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_aluin1(ex_aluin1), .ex_aluin2(ex_aluin2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic r, v;
        logic [3:0] rs1, rs2, rd;
        logic wr, ld;
        logic [1:0] s1, s2;
        logic br, st, fl, xv;
        logic [3:0] xrd;
        logic [1:0] a1, a2;
    } vec_t;

    typedef struct packed {
        logic v, wr, ld;
        logic [3:0] rd;
    } ent_t;

    int checks = 0;
    int errors = 0;

    // Reference model: history of the two youngest issue slots (0 = EX, 1 = MEM)
    ent_t pipe [2];
    int   fl_left = 0;
    int   m_stalls = 0, m_fwds = 0, m_flushes = 0;
    logic m_stall, m_flush, m_issue, m_fwd;
    logic [3:0] n_rd;
    logic [1:0] n_a1, n_a2;

    function automatic vec_t mk(int r, int v, int rs1, int rs2, int rd,
                                int wr, int ld, int s1, int s2, int br,
                                int st, int fl, int xv, int xrd,
                                int a1, int a2);
        vec_t t;
        t.r = 1'(r); t.v = 1'(v);
        t.rs1 = 4'(rs1); t.rs2 = 4'(rs2); t.rd = 4'(rd);
        t.wr = 1'(wr); t.ld = 1'(ld);
        t.s1 = 2'(s1); t.s2 = 2'(s2); t.br = 1'(br);
        t.st = 1'(st); t.fl = 1'(fl); t.xv = 1'(xv);
        t.xrd = 4'(xrd); t.a1 = 2'(a1); t.a2 = 2'(a2);
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Find youngest in-flight writer of rs: EX non-load forwards, else hazard.
    function automatic void resolve(input logic used, input logic [3:0] rs,
                                    output logic fwd, output logic haz);
        logic found;
        fwd = 1'b0; haz = 1'b0; found = 1'b0;
        if (used && rs != 4'd0) begin
            for (int age = 0; age < 2; age++) begin
                if (!found && pipe[age].v && pipe[age].wr && pipe[age].rd == rs) begin
                    found = 1'b1;
                    if (age == 0 && !pipe[age].ld) fwd = 1'b1;
                    else haz = 1'b1;
                end
            end
        end
    endfunction

    task automatic model_eval();
        logic f1, h1, f2, h2;
        resolve(id_sel1 == 2'b01, id_rs1, f1, h1);
        resolve(id_sel2 == 2'b00, id_rs2, f2, h2);
        m_stall = rst && id_valid && fl_left == 0 && !ex_branch_taken && (h1 || h2);
        m_flush = rst && fl_left > 0;
        m_issue = rst && fl_left == 0 && !ex_branch_taken && id_valid && !m_stall;
        m_fwd   = m_issue && (f1 || f2);
        n_rd = m_issue ? id_rd : 4'd0;
        n_a1 = m_issue ? (f1 ? 2'b10 : id_sel1) : 2'b00;
        n_a2 = m_issue ? (f2 ? 2'b11 : id_sel2) : 2'b00;
    endtask

    task automatic model_commit();
        if (!rst) begin
            pipe[0] = '0; pipe[1] = '0;
            fl_left = 0;
            m_stalls = 0; m_fwds = 0; m_flushes = 0;
        end else begin
            if (m_stall && m_stalls < 65535) m_stalls++;
            if (m_fwd && m_fwds < 65535) m_fwds++;
            if (fl_left == 0 && ex_branch_taken && m_flushes < 65535) m_flushes++;
            pipe[1] = pipe[0];
            pipe[0] = '{v: m_issue, wr: m_issue && id_wr,
                        ld: m_issue && id_load, rd: n_rd};
            if (fl_left > 0) fl_left--;
            else if (ex_branch_taken) fl_left = FC;
        end
    endtask

    task automatic apply(input vec_t t, input bit use_m);
        rst = t.r; id_valid = t.v;
        id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
        id_wr = t.wr; id_load = t.ld;
        id_sel1 = t.s1; id_sel2 = t.s2;
        ex_branch_taken = t.br;
        model_eval();
        if (use_m) begin
            t.st = m_stall; t.fl = m_flush; t.xv = m_issue;
            t.xrd = n_rd; t.a1 = n_a1; t.a2 = n_a2;
        end
        #2;
        chk("stall", stall, t.st);
        chk("flush", flush, t.fl);
        @(posedge clk);
        #1;
        model_commit();
        chk("ex_valid", ex_valid, t.xv);
        chk("ex_rd", ex_rd, t.xrd);
        chk("ex_aluin1", ex_aluin1, t.a1);
        chk("ex_aluin2", ex_aluin2, t.a2);
    endtask

    vec_t tbl1[$];
    vec_t tbl2[$];

    initial begin
        pipe[0] = '0; pipe[1] = '0;
        //            r v rs1 rs2 rd wr ld s1 s2 br | st fl xv xrd a1 a2
        tbl1.push_back(mk(0,1, 1, 2, 7, 1,0, 1,0,0,  0,0,0, 0,0,0));
        tbl1.push_back(mk(0,1, 1, 2, 7, 1,0, 1,0,0,  0,0,0, 0,0,0));
        tbl1.push_back(mk(1,1, 1, 2, 3, 1,0, 0,2,0,  0,0,1, 3,0,2));
        tbl1.push_back(mk(1,1, 3, 3, 6, 1,0, 1,0,0,  0,0,1, 6,2,3));
        tbl1.push_back(mk(1,1, 0, 0, 5, 1,1, 0,2,0,  0,0,1, 5,0,2));
        tbl1.push_back(mk(1,1, 0, 5, 1, 1,0, 3,0,0,  1,0,0, 0,0,0));
        tbl1.push_back(mk(1,1, 0, 5, 1, 1,0, 3,0,0,  1,0,0, 0,0,0));
        tbl1.push_back(mk(1,1, 0, 5, 1, 1,0, 3,0,0,  0,0,1, 1,3,0));
        tbl1.push_back(mk(1,1, 0, 0, 4, 1,0, 0,2,0,  0,0,1, 4,0,2));
        tbl1.push_back(mk(1,1, 0, 0, 2, 1,0, 3,1,0,  0,0,1, 2,3,1));
        tbl1.push_back(mk(1,1, 4, 0, 7, 0,0, 1,2,0,  1,0,0, 0,0,0));
        tbl1.push_back(mk(1,1, 4, 0, 7, 0,0, 1,2,0,  0,0,1, 7,1,2));
        tbl1.push_back(mk(1,1, 0, 0, 9, 1,1, 0,2,0,  0,0,1, 9,0,2));
        tbl1.push_back(mk(1,1, 9, 0, 8, 1,0, 1,2,1,  0,0,0, 0,0,0));
        tbl1.push_back(mk(1,1, 9, 0, 8, 1,0, 1,2,0,  0,1,0, 0,0,0));
        tbl1.push_back(mk(1,1, 9, 0, 8, 1,0, 1,2,1,  0,1,0, 0,0,0));
        tbl1.push_back(mk(1,1, 9, 0, 8, 1,0, 1,2,0,  0,0,1, 8,1,2));
        tbl1.push_back(mk(1,1, 0, 0, 0, 1,0, 0,2,0,  0,0,1, 0,0,2));
        tbl1.push_back(mk(1,1, 0, 0, 3, 1,0, 1,0,0,  0,0,1, 3,1,0));
        tbl1.push_back(mk(1,1, 3, 3, 5, 1,0, 0,2,0,  0,0,1, 5,0,2));
        tbl1.push_back(mk(1,1, 0, 0, 6, 1,0, 0,2,0,  0,0,1, 6,0,2));
        tbl1.push_back(mk(1,1, 6, 5,10, 1,0, 1,0,0,  1,0,0, 0,0,0));
        tbl1.push_back(mk(1,1, 6, 5,10, 1,0, 1,0,0,  1,0,0, 0,0,0));
        tbl1.push_back(mk(1,1, 6, 5,10, 1,0, 1,0,0,  0,0,1,10,1,0));
        tbl1.push_back(mk(1,0, 0, 0, 0, 0,0, 0,0,0,  0,0,0, 0,0,0));
        // reset during flush, then reset during a load-use stall
        tbl2.push_back(mk(1,1, 0, 0, 1, 1,0, 0,2,1,  0,0,0, 0,0,0));
        tbl2.push_back(mk(0,1, 0, 0, 1, 1,0, 0,2,0,  0,0,0, 0,0,0));
        tbl2.push_back(mk(1,1, 0, 0, 2, 1,0, 0,2,0,  0,0,1, 2,0,2));
        tbl2.push_back(mk(1,1, 0, 0, 3, 1,1, 0,2,0,  0,0,1, 3,0,2));
        tbl2.push_back(mk(1,1, 3, 0, 4, 1,0, 1,2,0,  1,0,0, 0,0,0));
        tbl2.push_back(mk(0,1, 3, 0, 4, 1,0, 1,2,0,  0,0,0, 0,0,0));
        tbl2.push_back(mk(1,1, 3, 0, 4, 1,0, 1,2,0,  0,0,1, 4,1,2));

        foreach (tbl1[i]) apply(tbl1[i], 1'b0);
`ifdef EX_ISSUE_STATS_EN
        chk("stat_stalls", stat_stalls, 5);
        chk("stat_fwds", stat_fwds, 1);
        chk("stat_flushes", stat_flushes, 1);
`endif
        foreach (tbl2[i]) apply(tbl2[i], 1'b0);

        for (int i = 0; i < 2000; i++) begin
            vec_t t;
            t = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
            t.r   = ($urandom_range(0, 99) >= 3);
            t.v   = ($urandom_range(0, 99) < 80);
            t.rs1 = 4'($urandom_range(0, 3));
            t.rs2 = 4'($urandom_range(0, 3));
            t.rd  = 4'($urandom_range(0, 3));
            t.wr  = ($urandom_range(0, 99) < 75);
            t.ld  = ($urandom_range(0, 99) < 30);
            t.s1  = 2'($urandom);
            t.s2  = 2'($urandom);
            t.br  = ($urandom_range(0, 99) < 10);
            apply(t, 1'b1);
        end
`ifdef EX_ISSUE_STATS_EN
        chk("stat_stalls_rand", stat_stalls, m_stalls);
        chk("stat_fwds_rand", stat_fwds, m_fwds);
        chk("stat_flushes_rand", stat_flushes, m_flushes);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_issue_controller.md
Name: ex_issue_controller

Overview:
- Issue/hazard controller sitting between decode and `execute_cycle`.
- Tracks the destination registers of the two instructions in flight (EX, MEM) in a small scoreboard shift register.
- Each cycle it picks the `aluin1`/`aluin2` mux selects for the instruction entering EX (including the `forwarded_aluout` path), stalls decode on unresolvable hazards, and inserts bubbles after taken branches.
- All EX-side outputs are registered and feed `execute_cycle` directly.

Parameters:
- REG_BITS, 4, register index width.
- FLUSH_CYCLES, 2, bubbles inserted after a taken branch (legal range 1..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- id_valid  in  1  decode holds a valid instruction
- id_rs1  in  REG_BITS  source register feeding operand a
- id_rs2  in  REG_BITS  source register feeding operand b
- id_rd  in  REG_BITS  destination register
- id_wr  in  1  instruction writes `id_rd`
- id_load  in  1  instruction is a memory load (result available only after MEM)
- id_sel1  in  2  decoder's native aluin1 select: 00 pc, 01 a, 10 reserved, 11 zero
- id_sel2  in  2  decoder's native aluin2 select: 00 b, 01 const 2, 10 imm, 11 reserved
- ex_branch_taken  in  1  EX resolved a taken branch this cycle
- stall  out  1  hold PC/IF/ID this cycle (combinational)
- flush  out  1  kill IF/ID contents this cycle (combinational from state)
- ex_valid  out  1  registered: EX instruction is real (0 = bubble)
- ex_rd  out  REG_BITS  registered rd for EX
- ex_aluin1  out  2  registered aluin1 select
- ex_aluin2  out  2  registered aluin2 select

Behaviour:
- Reset (rst==0 at posedge):
  - ex_valid, ex_rd, ex_aluin1, ex_aluin2 = 0; scoreboard entries invalid; FSM=RUN; flush counter=0.
  - stall=0 and flush=0 while reset is held.
- Scoreboard:
  - EX entry {v,wr,load,rd} = registered issue; MEM entry = previous EX entry, shifted every cycle (including stall cycles).
  - A bubble enters EX as v=0.
- Operand use:
  - rs1 is used iff id_sel1==01.
  - rs2 is used iff id_sel2==00.
  - Register 0 is never a hazard.
- Per used source s, priority order:
  1. EX entry v&wr&rd==s&!load → forward: sel1 becomes 10, sel2 becomes 11.
  2. EX entry v&wr&rd==s&load → hazard.
  3. MEM entry v&wr&rd==s (and no EX match) → hazard. The regfile is write-first in WB, so one more cycle resolves it.
  4. Otherwise → native select.
- stall = id_valid & RUN & ~ex_branch_taken & (any hazard).
  - Load-use therefore costs exactly 2 stall cycles.
- Issue at posedge:
  - In RUN with id_valid & ~stall & ~ex_branch_taken: ex_valid=1, ex_rd=id_rd, selects as resolved above.
  - Otherwise a bubble: ex_valid=0, selects=00, ex_rd=0, scoreboard entry invalid.
- FSM RUN:
  - ex_branch_taken → FLUSH, counter=FLUSH_CYCLES-1, bubble issued.
  - Branch has priority over stall and issue in the same cycle.
- FSM FLUSH:
  - flush=1, stall=0, only bubbles are issued, id_* ignored.
  - counter==0 → RUN, else counter-1.
  - ex_branch_taken is ignored in FLUSH: only bubbles are in EX.
- Reset asserted mid-stall or mid-flush returns to RUN with the scoreboard cleared on that edge.
- Both sources matching different hazards: stall if either source is a hazard; forwarding still applies to the other source once issued.

Optional Feature:
- EX_ISSUE_STATS_EN: adds outputs stat_stalls[15:0], stat_fwds[15:0], stat_flushes[15:0].
  - stat_stalls: +1 per stall cycle.
  - stat_fwds: +1 per issued instruction with at least one forwarded operand.
  - stat_flushes: +1 per branch taken in RUN.
  - All three saturate at 16'hFFFF and reset to 0.
- Without the macro the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with id_valid=1 → ex_valid=0, ex_aluin1=0, ex_aluin2=0, stall=0, flush=0; release → next issue proceeds normally.
- EX forward: issue rd=3 wr (non-load), then rs1=3, sel1=01 and rs2=3, sel2=00 → ex_aluin1=10, ex_aluin2=11, stall=0.
- Load-use: issue load rd=5, then consumer rs2=5, sel2=00 → stall=1 for exactly 2 cycles, two bubbles in EX, then issue with ex_aluin2=00.
- MEM-only dependency: rd=4 writer, an independent instruction, then rs1=4 sel1=01 → 1 stall cycle, then ex_aluin1=01.
- Branch: ex_branch_taken pulse with FLUSH_CYCLES=2 while a hazard stall is pending → flush=1 for 2 cycles, 3 bubbles total (branch cycle plus 2), stall=0 throughout, then RUN.
- Register-0 and non-use: rs1=0 after a writer of rd=0, and sel1=00 with a matching rs1 → no stall, no forward; with EX_ISSUE_STATS_EN the counters match the expected totals.
